// File: rtl/cordic_rotation_core.sv
// cordic_rotation_core
//   Iterative CORDIC engine in rotation mode. It performs one micro-rotation
//   per clock and returns cos/sin of a signed Q3.29 angle. The arctan(2^-j)
//   constants come from an external combinational table addressed by lut_j.
//   One transaction is in flight at a time.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   angle handshake (ready only in IDLE)
//   angle_in            signed Q3.29 angle in radians
//   lut_j / lut_arctan  table index out, arctan(2^-lut_j) in (Q3.29)
//   out_valid/out_ready result handshake
//   cos_out, sin_out    signed Q3.29 results
//   range_err           accepted angle was outside +/- pi/2
//   busy                high in ROTATE or DONE
module cordic_rotation_core #(
  parameter int                WIDTH  = 32,
  parameter int                ITER   = 16,
  parameter logic [WIDTH-1:0]  K_INIT = 32'h136E9DB5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] angle_in,
  output logic [4:0]              lut_j,
  input  logic signed [WIDTH-1:0] lut_arctan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] cos_out,
  output logic signed [WIDTH-1:0] sin_out,
  output logic                    range_err,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(32'h3243F6A9);

  state_t                  state;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] x_sh, y_sh, x_nx, y_nx, z_nx;
  logic [4:0]              j;

  // j returns to 0 when rotation ends, so the index is 0 outside ROTATE.
  assign lut_j = j;

  // One micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    x_sh = x >>> j;
    y_sh = y >>> j;
    if (!z[WIDTH-1]) begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - lut_arctan;
    end else begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + lut_arctan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      range_err <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      j         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x         <= K_INIT;
            y         <= '0;
            z         <= angle_in;
            j         <= '0;
            range_err <= (angle_in > HALF_PI) || (angle_in < -HALF_PI);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= ROTATE;
          end
        end
        ROTATE: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          if (j == 5'(ITER-1)) begin
            j         <= '0;
            cos_out   <= x_nx;
            sin_out   <= y_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            j <= j + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
